// File: rtl/zdraw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zdraw_scheduler
// Brief    : Draw-command scheduler: boot pass over boot-masked items, then
//            dirty-driven refresh passes separated by an idle gap; each command
//            uses an enable/done handshake guarded by a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module zdraw_scheduler #(
  parameter int N_ITEMS   = 8,
  parameter int CMD_W     = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1048576,
  parameter int FRAME_GAP = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_ITEMS-1:0]          iBoot_Mask,
  input  logic [N_ITEMS-1:0]          iItem_Mask,
  input  logic [N_ITEMS*CMD_W-1:0]    iItem_Cmd,
  input  logic [N_ITEMS*DATA_W-1:0]   iItem_Data1,
  input  logic [N_ITEMS*DATA_W-1:0]   iItem_Data2,
  input  logic [N_ITEMS-1:0]          iItem_Update,
  input  logic                        iForce_Refresh,
  output logic                        oCore_En,
  output logic [CMD_W-1:0]            oCore_Cmd,
  output logic [DATA_W-1:0]           oCore_Data1,
  output logic [DATA_W-1:0]           oCore_Data2,
  input  logic                        iCore_Done,
  output logic                        oBoot_Done,
  output logic                        oFrame_Done,
  output logic                        oTimeout,
  output logic                        oBusy
);

  localparam int c_PTR_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int c_CNT_MAX = (TIMEOUT > FRAME_GAP) ? TIMEOUT : FRAME_GAP;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(N_ITEMS - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(FRAME_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOOT_SCAN  = 3'd1,
    S_BOOT_ISSUE = 3'd2,
    S_SCAN       = 3'd3,
    S_ISSUE      = 3'd4,
    S_GAP        = 3'd5
  } state_t;

  state_t               r_state, w_stateNxt;
  logic [c_PTR_W-1:0]   r_ptr, w_ptrNxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cntNxt;
  logic [N_ITEMS-1:0]   r_dirty, w_dirtyNxt;
  logic                 r_coreEn, w_coreEnNxt;
  logic [CMD_W-1:0]     r_cmd, w_cmdNxt;
  logic [DATA_W-1:0]    r_data1, w_data1Nxt;
  logic [DATA_W-1:0]    r_data2, w_data2Nxt;
  logic                 r_bootDone, w_bootDoneNxt;
  logic                 r_frameDone, w_frameDoneNxt;
  logic                 r_timeout, w_timeoutNxt;

  logic [CMD_W-1:0]     w_cmdArr   [N_ITEMS];
  logic [DATA_W-1:0]    w_data1Arr [N_ITEMS];
  logic [DATA_W-1:0]    w_data2Arr [N_ITEMS];
  logic [N_ITEMS-1:0]   w_ptrOneHot;
  logic [N_ITEMS-1:0]   w_dirtySet, w_dirtyClr;
  logic                 w_itemSel, w_lastPtr, w_inBoot, w_passEnd;

  generate
    for (genvar k = 0; k < N_ITEMS; k++) begin : g_unpack
      assign w_cmdArr[k]   = iItem_Cmd[k*CMD_W +: CMD_W];
      assign w_data1Arr[k] = iItem_Data1[k*DATA_W +: DATA_W];
      assign w_data2Arr[k] = iItem_Data2[k*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_ptrOneHot = {{(N_ITEMS-1){1'b0}}, 1'b1} << r_ptr;
  assign w_lastPtr   = (r_ptr == c_LAST_PTR);
  assign w_inBoot    = (r_state == S_BOOT_SCAN) || (r_state == S_BOOT_ISSUE);
  assign w_itemSel   = (r_state == S_BOOT_SCAN) ? iBoot_Mask[r_ptr]
                                                : (r_dirty[r_ptr] & iItem_Mask[r_ptr]);

  always_comb begin
    w_stateNxt     = r_state;
    w_ptrNxt       = r_ptr;
    w_cntNxt       = r_cnt;
    w_coreEnNxt    = r_coreEn;
    w_cmdNxt       = r_cmd;
    w_data1Nxt     = r_data1;
    w_data2Nxt     = r_data2;
    w_bootDoneNxt  = r_bootDone;
    w_frameDoneNxt = 1'b0;
    w_timeoutNxt   = 1'b0;
    w_dirtySet     = iItem_Update | (iForce_Refresh ? iItem_Mask : '0);
    w_dirtyClr     = '0;
    w_passEnd      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_stateNxt = S_BOOT_SCAN;
        w_ptrNxt   = '0;
        w_cntNxt   = '0;
      end
      S_BOOT_SCAN, S_SCAN: begin
        if (w_itemSel) begin
          w_cmdNxt    = w_cmdArr[r_ptr];
          w_data1Nxt  = w_data1Arr[r_ptr];
          w_data2Nxt  = w_data2Arr[r_ptr];
          w_coreEnNxt = 1'b1;
          w_cntNxt    = '0;
          w_stateNxt  = w_inBoot ? S_BOOT_ISSUE : S_ISSUE;
          if (!w_inBoot) w_dirtyClr = w_ptrOneHot;
        end else if (w_lastPtr) begin
          w_passEnd = 1'b1;
        end else begin
          w_ptrNxt = r_ptr + 1'b1;
        end
      end
      S_BOOT_ISSUE, S_ISSUE: begin
        if (iCore_Done || (r_cnt == c_TMO_LAST)) begin
          w_coreEnNxt = 1'b0;
          // A command that never completed is redrawn on the next refresh pass.
          if (!iCore_Done) begin
            w_timeoutNxt = 1'b1;
            if (!w_inBoot) w_dirtySet = w_dirtySet | w_ptrOneHot;
          end
          if (w_lastPtr) begin
            w_passEnd = 1'b1;
          end else begin
            w_ptrNxt   = r_ptr + 1'b1;
            w_stateNxt = w_inBoot ? S_BOOT_SCAN : S_SCAN;
          end
        end else begin
          w_cntNxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_stateNxt = S_SCAN;
          w_ptrNxt   = '0;
        end else begin
          w_cntNxt = r_cnt + 1'b1;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase

    if (w_passEnd) begin
      w_ptrNxt = '0;
      w_cntNxt = '0;
      if (w_inBoot) begin
        w_bootDoneNxt = 1'b1;
        w_dirtySet    = w_dirtySet | iItem_Mask;
        w_stateNxt    = S_SCAN;
      end else begin
        w_frameDoneNxt = 1'b1;
        w_stateNxt     = S_GAP;
      end
    end

    // Set wins over clear so an update racing the snapshot is not lost.
    w_dirtyNxt = (r_dirty & ~w_dirtyClr) | w_dirtySet;

    if (!en) begin
      w_stateNxt     = S_IDLE;
      w_ptrNxt       = '0;
      w_cntNxt       = '0;
      w_dirtyNxt     = '0;
      w_coreEnNxt    = 1'b0;
      w_bootDoneNxt  = 1'b0;
      w_frameDoneNxt = 1'b0;
      w_timeoutNxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_dirty     <= '0;
      r_coreEn    <= 1'b0;
      r_cmd       <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_bootDone  <= 1'b0;
      r_frameDone <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_ptr       <= w_ptrNxt;
      r_cnt       <= w_cntNxt;
      r_dirty     <= w_dirtyNxt;
      r_coreEn    <= w_coreEnNxt;
      r_cmd       <= w_cmdNxt;
      r_data1     <= w_data1Nxt;
      r_data2     <= w_data2Nxt;
      r_bootDone  <= w_bootDoneNxt;
      r_frameDone <= w_frameDoneNxt;
      r_timeout   <= w_timeoutNxt;
    end
  end

  assign oCore_En    = r_coreEn;
  assign oCore_Cmd   = r_cmd;
  assign oCore_Data1 = r_data1;
  assign oCore_Data2 = r_data2;
  assign oBoot_Done  = r_bootDone;
  assign oFrame_Done = r_frameDone;
  assign oTimeout    = r_timeout;
  assign oBusy       = (r_state != S_IDLE) && (r_state != S_GAP);

endmodule
`default_nettype wire
